// File: rtl/fpu_add_issue.sv
// Result FIFO: show-ahead, DEPTH entries, pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at the head on the next cycle (no bypass).
// Backpressure: none internally; the caller never pushes when full and never pops when empty.
module fpu_add_issue_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       core_clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) wr_ptr <= wrap_inc(wr_ptr);
      if (pop_rdy)  rd_ptr <= wrap_inc(rd_ptr);
      if (push_vld && !pop_rdy)      cnt <= cnt + 1'b1;
      else if (!push_vld && pop_rdy) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// Issue/collect controller around fpu_add; optional sideband tag under FPU_ISSUE_TAG_EN.
// Latency: accept in cycle 0, result captured in cycle LAT, OUT_VALID in cycle LAT+1.
// Backpressure: IN_READY drops when OCC reaches DEPTH, so every in-flight result has a FIFO slot.
module fpu_add_issue #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [31:0]                IN_A,
  input  logic [31:0]                IN_B,
`ifdef FPU_ISSUE_TAG_EN
  input  logic [TAG_W-1:0]           IN_TAG,
`endif
  output logic                       FPU_EN,
  output logic [31:0]                FPU_A,
  output logic [31:0]                FPU_B,
  input  logic [31:0]                FPU_Z,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [31:0]                OUT_Z,
`ifdef FPU_ISSUE_TAG_EN
  output logic [TAG_W-1:0]           OUT_TAG,
`endif
  output logic [$clog2(DEPTH+1)-1:0] OCC
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FPU_ISSUE_TAG_EN
  localparam int EW = 32 + TAG_W;
`else
  // TAG_W stays referenced so both builds share one parameter list.
  localparam int EW = 32 + 0 * TAG_W;
`endif

  logic           acc;
  logic           push;
  logic           pop;
  logic [LAT-1:0] vp;
  logic [EW-1:0]  push_dat;
  logic [EW-1:0]  head_dat;
  logic [CW-1:0]  fifo_cnt;

  assign IN_READY = (OCC != CW'(DEPTH));
  assign acc      = IN_VALID & IN_READY;
  assign FPU_EN   = acc;
  assign FPU_A    = IN_A;
  assign FPU_B    = IN_B;

  // vp mirrors the fpu_add pipe; its tail marks the cycle FPU_Z is genuine.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vp  <= '0;
      OCC <= '0;
    end else begin
      vp[0] <= acc;
      for (int i = 1; i < LAT; i++) vp[i] <= vp[i-1];
      if (acc && !pop)      OCC <= OCC + 1'b1;
      else if (!acc && pop) OCC <= OCC - 1'b1;
    end
  end

  assign push = vp[LAT-1];

`ifdef FPU_ISSUE_TAG_EN
  logic [TAG_W-1:0] tp [LAT];

  always_ff @(posedge CLK) begin
    tp[0] <= IN_TAG;
    for (int i = 1; i < LAT; i++) tp[i] <= tp[i-1];
  end

  assign push_dat = {FPU_Z, tp[LAT-1]};
  assign OUT_Z    = head_dat[EW-1:TAG_W];
  assign OUT_TAG  = head_dat[TAG_W-1:0];
`else
  assign push_dat = FPU_Z;
  assign OUT_Z    = head_dat;
`endif

  fpu_add_issue_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .core_clk (CLK),
    .rst      (RESET),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .head_dat (head_dat),
    .cnt      (fifo_cnt)
  );

  assign OUT_VALID = (fifo_cnt != '0);
  assign pop       = OUT_VALID & OUT_READY;

endmodule

// File: tb/tb_fpu_add_issue.sv
// Directed bench for fpu_add_issue with a behavioural fpu_add (table of hand-computed sums).
module tb_fpu_add_issue;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_A = '0;
  logic [31:0] IN_B = '0;
  logic        FPU_EN;
  logic [31:0] FPU_A;
  logic [31:0] FPU_B;
  logic [31:0] FPU_Z;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_Z;
  logic [3:0]  OCC;
`ifdef FPU_ISSUE_TAG_EN
  logic [TAG_W-1:0] IN_TAG = '0;
  logic [TAG_W-1:0] OUT_TAG;
`endif

  fpu_add_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
`ifdef FPU_ISSUE_TAG_EN
    .IN_TAG    (IN_TAG),
`endif
    .FPU_EN    (FPU_EN),
    .FPU_A     (FPU_A),
    .FPU_B     (FPU_B),
    .FPU_Z     (FPU_Z),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_Z     (OUT_Z),
`ifdef FPU_ISSUE_TAG_EN
    .OUT_TAG   (OUT_TAG),
`endif
    .OCC       (OCC)
  );

  always #5 CLK = ~CLK;

  // Operand vectors and their binary32 sums, worked out by hand.
  logic [31:0] va    [8] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                             32'h3F000000, 32'h40000000, 32'h41200000, 32'h40800000};
  logic [31:0] vb    [8] = '{32'h40000000, 32'h3F800000, 32'hBFC00000, 32'h40000000,
                             32'h3F000000, 32'h40400000, 32'h3F800000, 32'h40800000};
  logic [31:0] exp_z [8] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h40800000,
                             32'h3F800000, 32'h40A00000, 32'h41300000, 32'h41000000};

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h3FC00000_BFC00000: return 32'h00000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      64'h40000000_40400000: return 32'h40A00000;
      64'h41200000_3F800000: return 32'h41300000;
      64'h40800000_40800000: return 32'h41000000;
      default:               return 32'h7FC00000;
    endcase
  endfunction

  // fpu_add model: stage 0 holds its last sum while EN is low, so stale values recirculate.
  logic [31:0] st [LAT];
  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LAT; i++) st[i] <= '0;
    end else begin
      if (FPU_EN) st[0] <= fadd(FPU_A, FPU_B);
      for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
    end
  end
  assign FPU_Z = st[LAT-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [31:0] z_q [$];
  int          c_q [$];
  logic [3:0]  t_q [$];

  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      z_q.push_back(OUT_Z);
      c_q.push_back(cyc);
`ifdef FPU_ISSUE_TAG_EN
      t_q.push_back(4'(OUT_TAG));
`endif
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic mid;
    @(negedge CLK);
  endtask

  task automatic clear_q;
    z_q.delete();
    c_q.delete();
    t_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int base;
  int n_acc;

  initial begin
    tick; tick;
    RESET = 1'b0;
    mid;
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_occ", OCC, 0);
    check("rst_fpu_en", FPU_EN, 0);

    // Single op: result in cycle 6, OCC back to 0 in cycle 7.
    clear_q();
    tick;
    IN_VALID = 1'b1; IN_A = va[0]; IN_B = vb[0]; OUT_READY = 1'b1;
    mid;
    check("single_fpu_en", FPU_EN, 1);
    check("single_fpu_a", FPU_A, va[0]);
    for (int k = 1; k <= 7; k++) begin
      tick;
      IN_VALID = 1'b0;
      mid;
      if (k == 5) check("single_not_early", OUT_VALID, 0);
      if (k == 6) begin
        check("single_out_valid", OUT_VALID, 1);
        check("single_out_z", OUT_Z, 32'h40400000);
      end
      if (k == 7) begin
        check("single_occ_zero", OCC, 0);
        check("single_out_valid_low", OUT_VALID, 0);
      end
    end

    // Back-to-back: 8 ops in consecutive cycles, results on cycles 6..13.
    clear_q();
    tick;
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick;
      IN_VALID = 1'b1; IN_A = va[i]; IN_B = vb[i];
      mid;
      check("b2b_in_ready", IN_READY, 1);
    end
    tick;
    IN_VALID = 1'b0;
    repeat (16) tick;
    check("b2b_count", z_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < z_q.size()) begin
        check("b2b_z", z_q[i], exp_z[i]);
        check("b2b_cycle", c_q[i] - base, 6 + i);
      end
    end

    // Backpressure: fill to OCC=8, hold, then drain.
    clear_q();
    OUT_READY = 1'b0;
    n_acc = 0;
    for (int g = 0; g < 20 && n_acc < 8; g++) begin
      tick;
      IN_VALID = 1'b1; IN_A = va[n_acc]; IN_B = vb[n_acc];
      mid;
      if (IN_READY) n_acc++;
    end
    check("bp_accepts", n_acc, 8);
    tick;
    IN_A = va[0]; IN_B = vb[0];
    mid;
    check("bp_in_ready_low", IN_READY, 0);
    check("bp_occ_full", OCC, 8);
    check("bp_no_accept", FPU_EN, 0);
    repeat (4) tick;
    mid;
    check("bp_out_z_stable", OUT_Z, exp_z[0]);
    check("bp_still_full", IN_READY, 0);
    tick;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    mid;
    check("bp_ready_during_pop", IN_READY, 0);
    tick;
    mid;
    check("bp_ready_back", IN_READY, 1);
    check("bp_occ_after_pop", OCC, 7);
    repeat (12) tick;
    check("bp_count", z_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < z_q.size()) check("bp_z", z_q[i], exp_z[i]);

    // Simultaneous accept and pop at OCC=5.
    clear_q();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      IN_VALID = 1'b1; IN_A = va[i]; IN_B = vb[i];
    end
    tick;
    IN_VALID = 1'b0;
    repeat (8) tick;
    mid;
    check("sim_occ_before", OCC, 5);
    tick;
    IN_VALID = 1'b1; IN_A = va[5]; IN_B = vb[5]; OUT_READY = 1'b1;
    mid;
    check("sim_acc", FPU_EN, 1);
    tick;
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    mid;
    check("sim_occ_same", OCC, 5);
    tick;
    OUT_READY = 1'b1;
    repeat (14) tick;
    mid;
    check("sim_occ_drained", OCC, 0);
    check("sim_count", z_q.size(), 6);
    if (z_q.size() == 6) begin
      check("sim_first_z", z_q[0], exp_z[0]);
      check("sim_last_z", z_q[5], exp_z[5]);
    end

    // Reset with 2 results queued and 3 in the pipe.
    clear_q();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      IN_VALID = 1'b1; IN_A = va[i]; IN_B = vb[i];
    end
    tick;
    IN_VALID = 1'b0;
    tick;
    tick;
    RESET = 1'b1;
    mid;
    check("rmf_queued", OUT_VALID, 1);
    check("rmf_occ_pre", OCC, 5);
    tick;
    RESET = 1'b0;
    mid;
    check("rmf_out_valid", OUT_VALID, 0);
    check("rmf_occ", OCC, 0);
    check("rmf_in_ready", IN_READY, 1);
    tick;
    OUT_READY = 1'b1;
    repeat (14) tick;
    mid;
    check("rmf_no_stale", z_q.size(), 0);
    check("rmf_occ_after", OCC, 0);

`ifdef FPU_ISSUE_TAG_EN
    // Tags 1..8 under random OUT_READY.
    clear_q();
    n_acc = 0;
    for (int g = 0; g < 300 && z_q.size() < 8; g++) begin
      tick;
      OUT_READY = 1'($urandom_range(0, 1));
      IN_VALID  = (n_acc < 8);
      if (n_acc < 8) begin
        IN_A = va[n_acc]; IN_B = vb[n_acc]; IN_TAG = TAG_W'(n_acc + 1);
      end
      mid;
      if (IN_VALID && IN_READY) n_acc++;
    end
    tick;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    check("tag_count", z_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < z_q.size()) begin
        check("tag_val", t_q[i], 32'(i + 1));
        check("tag_z", z_q[i], exp_z[i]);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_add_issue.md
# fpu_add_issue

Issue and result-collection controller that sits directly upstream and downstream of the `fpu_add` pipeline. It accepts operand pairs over a valid/ready handshake and drives `fpu_add` operands and enable. It tracks each accepted operation through the fixed pipeline latency and captures each result into a result FIFO for a valid/ready consumer. A credit counter guarantees that no result leaving the pipeline is ever dropped.

## Interface
Parameters:
- `LAT`, default 5: `fpu_add` latency in cycles. Operands driven with EN high in cycle t appear on Z in cycle t+LAT.
- `DEPTH`, default 8: result FIFO entries. Legal range is 2 or more. DEPTH ≥ LAT+2 is required for full throughput.
- `TAG_W`, default 4: tag width. Used only with `FPU_ISSUE_TAG_EN`.

Ports:
- `CLK`  in  1: sole clock, rising edge.
- `RESET`  in  1: synchronous, active-high.
- `IN_VALID`  in  1: operand pair offered.
- `IN_READY`  out  1: block can accept.
- `IN_A`  in  32: binary32 operand A.
- `IN_B`  in  32: binary32 operand B.
- `IN_TAG`  in  TAG_W: sideband tag. Present only with `FPU_ISSUE_TAG_EN`.
- `FPU_EN`  out  1: to `fpu_add` EN.
- `FPU_A`  out  32: to `fpu_add` A.
- `FPU_B`  out  32: to `fpu_add` B.
- `FPU_Z`  in  32: from `fpu_add` Z.
- `OUT_VALID`  out  1: result available at FIFO head.
- `OUT_READY`  in  1: consumer takes result.
- `OUT_Z`  out  32: head result.
- `OUT_TAG`  out  TAG_W: head tag. Present only with `FPU_ISSUE_TAG_EN`.
- `OCC`  out  $clog2(DEPTH+1): operations in flight plus results queued.

## Operation
- Accept: `acc = IN_VALID & IN_READY`.
- Operand path: `FPU_A = IN_A` and `FPU_B = IN_B`, combinational. `FPU_EN = acc`.
  - While `FPU_EN` is low, `fpu_add` re-circulates stale operands. The block ignores those outputs.
- Valid tracker: LAT-bit shift register `vp`.
  - Update each cycle: `vp[0] <= acc`, `vp[i] <= vp[i-1]`.
  - `push = vp[LAT-1]`. The cycle in which `push` is high is exactly the cycle in which `FPU_Z` holds that operation's result.
- Result FIFO: DEPTH entries of {Z, tag}, show-ahead.
  - `OUT_VALID = (count != 0)`.
  - `OUT_Z` and `OUT_TAG` reflect the head entry.
  - `pop = OUT_VALID & OUT_READY`.
  - Read and write pointers wrap modulo DEPTH. Simultaneous push and pop are legal in any state, including empty-with-push: the pushed entry becomes visible next cycle with no bypass.
- Credit counter `OCC`:
  - +1 on `acc`, −1 on `pop`, unchanged when both or neither occur.
  - `push` does not change `OCC`, because the operation moves from in flight to queued.
- `IN_READY = (OCC != DEPTH)`. It is registered-state only, with no combinational path from `OUT_READY` or `IN_VALID`.
- Invariant: in-flight count + FIFO count = `OCC` ≤ DEPTH. FIFO overflow is therefore impossible, and push never meets a full FIFO.
- Order: results leave in acceptance order.
- States implied by `OCC`:
  - IDLE (`OCC` = 0)
  - BUSY (0 < `OCC` < DEPTH)
  - FULL (`OCC` = DEPTH, `IN_READY` = 0)
  - In FULL, a pop returns the block to BUSY next cycle.

## Timing
- Reset values: `IN_READY` = 1, `OUT_VALID` = 0, `OCC` = 0, `FPU_EN` = 0. `OUT_Z` and `OUT_TAG` are don't-care while `OUT_VALID` = 0.
- Reset clears `vp`, the FIFO pointers, the count, and `OCC` in the same edge.
- RESET mid-operation discards all in-flight and queued results. `fpu_add` shares the same RESET.
- Latency: accept in cycle 0, then push in cycle LAT, then `OUT_VALID` in cycle LAT+1. The minimum is 6 cycles at default.
- Throughput: 1 operation per cycle sustained when `OUT_READY` stays high and DEPTH ≥ LAT+2.
- Handshake rules:
  - `OUT_Z` and `OUT_TAG` are stable while `OUT_VALID` is high and `OUT_READY` is low.
  - `IN_VALID` may drop without being accepted.

## Configuration
- `FPU_ISSUE_TAG_EN` defined:
  - `IN_TAG` and `OUT_TAG` ports exist.
  - The tag travels through a LAT-deep shift register aligned with `vp` and is stored in the FIFO beside Z.
  - `OUT_TAG` returns the tag accepted with that result.
- `FPU_ISSUE_TAG_EN` undefined:
  - Tag ports, tag pipe and tag storage are absent.
  - All other behaviour is identical.

## Test plan
- Single op: A=0x3F800000, B=0x40000000 accepted in cycle 0 with `OUT_READY`=1. Required: `OUT_VALID` high in cycle 6 with `OUT_Z`=0x40400000, and `OCC` back to 0 in cycle 7.
- Back-to-back: 8 ops in consecutive cycles, including 0x3F800000+0x3F800000 → 0x40000000 and 0x3FC00000+0xBFC00000 → 0x00000000. Required: `IN_READY` never drops, and the results appear in order on consecutive cycles 6..13.
- Backpressure: `OUT_READY`=0 while streaming. Required:
  - `IN_READY` falls after 8 accepts, with `OCC`=8.
  - No result is lost.
  - Raising `OUT_READY` drains all 8 results in order, and `IN_READY` returns the cycle after the first pop.
- Simultaneous accept and pop at `OCC`=5. Required: `OCC` stays 5.
- Reset mid-flight with 3 ops in the pipe and 2 queued. Required:
  - The cycle after reset: `OUT_VALID`=0, `OCC`=0, `IN_READY`=1.
  - No stale result is ever emitted.
- With `FPU_ISSUE_TAG_EN`: tags 0x1..0x8 on 8 ops under random `OUT_READY`. Required: `OUT_TAG` returns 0x1..0x8 in order, each paired with its own result.
